mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Memory-stage request controller on the consumer side of the EX/MEM latch. It turns the latched dREN/dWEN, address and store data into a held request to the data cache, and waits for dhit. It captures load data and freezes the upstream pipeline latches while the access is pending. It also blocks re-issue of a completed access during the cycle before the EX/MEM latch clears, and reports halt once memory is quiescent.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
WAIT_MAX, 255, wait-cycle limit before err_timeout; counter width is clog2(WAIT_MAX+1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
dREN_i  in  1  latched load request from EX/MEM
dWEN_i  in  1  latched store request from EX/MEM
addr_i  in  ADDR_W  latched ALU result (port_out)
store_i  in  DATA_W  latched store data (rdat2)
halt_i  in  1  latched halt
dhit  in  1  cache access complete, single-cycle pulse
dmemload  in  DATA_W  cache read data, valid with dhit
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  ADDR_W  cache address
dmemstore  out  DATA_W  cache write data
mem_stall  out  1  freeze upstream latches (en low)
load_o  out  DATA_W  captured load word
ld_valid  out  1  one-cycle pulse: load_o updated
halt_o  out  1  sticky halt
err_misalign  out  1  sticky misaligned-access flag
err_timeout  out  1  sticky wait-limit flag

Behaviour:
- Reset (any time, including mid-access):
  - state=IDLE, wait counter=0, load_o=0.
  - ld_valid, halt_o, err_misalign and err_timeout all 0.
  - The request is dropped at once, with no dhit required.
- States:
  - IDLE: no access outstanding.
  - WAIT: access issued, no dhit yet.
  - DONE: one-cycle guard after dhit.
- Request qualification:
  - req = (dREN_i|dWEN_i) & ~misalign & (state!=DONE).
  - misalign = addr_i[1:0]!=0.
- Request outputs, combinational from the latched inputs:
  - dmemWEN = req & dWEN_i.
  - dmemREN = req & dREN_i & ~dWEN_i. Write has priority if both are set; the read is ignored with no error.
  - dmemaddr = addr_i; dmemstore = store_i.
  - Outputs are held unchanged until dhit.
- mem_stall = req & ~dhit.
- Latency: a dhit in the issue cycle completes with 0 wait cycles. No upper bound otherwise.
- IDLE -> WAIT: req & ~dhit. IDLE -> DONE: req & dhit.
- WAIT -> DONE: dhit.
- WAIT, each cycle without dhit: wait counter +1, saturating at WAIT_MAX. err_timeout sets when the counter reaches WAIT_MAX. The request stays asserted (flag only).
- On dhit with a read:
  - load_o <= dmemload on that edge.
  - ld_valid=1 for exactly the following cycle.
  - A write dhit leaves load_o unchanged and ld_valid 0.
- DONE:
  - Lasts exactly one cycle; requests are suppressed and mem_stall=0.
  - Then DONE -> IDLE and the counter clears.
  - If new dREN/dWEN is present the cycle after DONE, it issues normally.
- Misaligned request:
  - No cache request and no stall; the access is dropped.
  - err_misalign sets on the next edge and stays set until reset.
- dhit while req=0 (IDLE or DONE): ignored; no state change, no capture.
- halt_o sets on the edge where halt_i=1 and state=IDLE and req=0. It is sticky until reset.
- A halt arriving during WAIT is deferred until the access completes and the block returns to IDLE.

Optional Feature:
MEM_STATS_EN
- Defined:
  - Adds outputs stat_loads, stat_stores and stat_wait, 32 bits each, all reset to 0.
  - stat_loads +1 per read dhit; stat_stores +1 per write dhit.
  - stat_wait +1 per WAIT cycle without dhit.
  - All three wrap modulo 2^32 and freeze while halt_o=1.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load, 3-cycle wait:
  - Stimulus: dREN_i=1, addr_i=0x100, dhit in cycle 3, dmemload=0xDEADBEEF.
  - Response: dmemREN=1 and mem_stall=1 in cycles 0-2. mem_stall=0 in cycle 3. load_o=0xDEADBEEF with a 1-cycle ld_valid in cycle 4. No request in cycle 4 (DONE).
- Store, same-cycle dhit:
  - Stimulus: dWEN_i=1, addr_i=0x204, store_i=0x12345678, dhit in cycle 0.
  - Response: dmemWEN=1 and dmemstore=0x12345678 in cycle 0. mem_stall=0 throughout. ld_valid never asserts.
- Both dREN_i=1 and dWEN_i=1 -> only dmemWEN asserts; dmemREN=0.
- Misaligned: dREN_i=1, addr_i=0x102 -> dmemREN=0, mem_stall=0, err_misalign=1 from the next cycle, held until RST.
- Timeout and reset mid-access:
  - Stimulus: WAIT_MAX=4, dREN_i=1, no dhit for 6 cycles, then RST pulsed in cycle 6.
  - Response: err_timeout=1 from cycle 4 onward while dmemREN stays 1. RST immediately forces dmemREN=0, mem_stall=0, state IDLE and all flags 0.
- Halt deferral:
  - Stimulus: halt_i=1 together with a pending load; dhit after 2 cycles.
  - Response: halt_o stays 0 during WAIT and DONE, rises one cycle after the block returns to IDLE, and stays 1 after halt_i drops.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle between the EX/MEM latch, the data cache and the memory-stage request controller.
// Latency: none, wires only.
// Backpressure: mem_stall freezes the upstream latches until dhit. Optional MEM_STATS_EN adds counter outputs.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // EX/MEM latch side
    logic              dREN_i;
    logic              dWEN_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] store_i;
    logic              halt_i;
    // data cache side
    logic              dhit;
    logic [DATA_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    // pipeline control and status
    logic              mem_stall;
    logic [DATA_W-1:0] load_o;
    logic              ld_valid;
    logic              halt_o;
    logic              err_misalign;
    logic              err_timeout;
`ifdef MEM_STATS_EN
    logic [31:0]       stat_loads;
    logic [31:0]       stat_stores;
    logic [31:0]       stat_wait;
`endif

    // Pipeline/cache environment view
    modport master (
        output dREN_i, dWEN_i, addr_i, store_i, halt_i, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               load_o, ld_valid, halt_o, err_misalign, err_timeout
`ifdef MEM_STATS_EN
        , input stat_loads, stat_stores, stat_wait
`endif
    );

    // Controller view
    modport slave (
        input  dREN_i, dWEN_i, addr_i, store_i, halt_i, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               load_o, ld_valid, halt_o, err_misalign, err_timeout
`ifdef MEM_STATS_EN
        , output stat_loads, stat_stores, stat_wait
`endif
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage request controller: holds a cache request from the EX/MEM latch until dhit and captures load data.
// Latency: request is combinational from the latch; load_o/ld_valid update on the dhit edge (0 wait cycles if dhit in the issue cycle).
// Backpressure: mem_stall = req & ~dhit freezes upstream; DONE guard suppresses re-issue. Optional MEM_STATS_EN adds access counters.
module mem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic           CLK,
    input  logic           RST,
    mem_access_ctrl_if.slave bus
);
    localparam int              CNT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_inc;
    logic [DATA_W-1:0]  load_q;
    logic               ld_valid_q;
    logic               halt_q;
    logic               misalign_q;
    logic               timeout_q;

    logic               access;
    logic               misalign;
    logic               req;
    logic               hit;
    logic               rd_hit;
    logic               wr_hit;
    logic               wait_cyc;

    // Request qualification. Reset is folded in so an in-flight request
    // disappears the moment RST rises, not at the next edge.
    assign access   = bus.dREN_i | bus.dWEN_i;
    assign misalign = bus.addr_i[1:0] != 2'b00;
    assign req      = access & ~misalign & (state != ST_DONE) & ~RST;
    assign hit      = req & bus.dhit;
    assign rd_hit   = hit & ~bus.dWEN_i;
    assign wr_hit   = hit & bus.dWEN_i;
    assign wait_cyc = req & ~bus.dhit;

    // Cache request straight from the latched inputs; writes win over reads
    assign bus.dmemWEN   = req & bus.dWEN_i;
    assign bus.dmemREN   = req & bus.dREN_i & ~bus.dWEN_i;
    assign bus.dmemaddr  = bus.addr_i;
    assign bus.dmemstore = bus.store_i;
    assign bus.mem_stall = wait_cyc;

    assign bus.load_o       = load_q;
    assign bus.ld_valid     = ld_valid_q;
    assign bus.halt_o       = halt_q;
    assign bus.err_misalign = misalign_q;
    assign bus.err_timeout  = timeout_q;

    // Saturating increment of the wait counter
    assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE is a one-cycle guard while the EX/MEM latch clears
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = bus.dhit ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hit) begin
                    state_nxt = ST_DONE;
                end else if (!req) begin
                    // Upstream withdrew the access; nothing left to wait for
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Wait counter: counts every stalled cycle of an access, cleared once it retires
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (state == ST_DONE || (state == ST_WAIT && !req)) begin
            wait_cnt <= '0;
        end else if (wait_cyc) begin
            wait_cnt <= wait_cnt_inc;
        end
    end

    // Load capture and its one-cycle valid pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            load_q     <= '0;
            ld_valid_q <= 1'b0;
        end else begin
            ld_valid_q <= rd_hit;
            if (rd_hit) begin
                load_q <= bus.dmemload;
            end
        end
    end

    // Sticky status flags; halt only once nothing is outstanding
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_q     <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (bus.halt_i && state == ST_IDLE && !req) begin
                halt_q <= 1'b1;
            end
            if (access && misalign) begin
                misalign_q <= 1'b1;
            end
            if (wait_cyc && wait_cnt_inc == CNT_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] stat_loads_q;
    logic [31:0] stat_stores_q;
    logic [31:0] stat_wait_q;

    assign bus.stat_loads  = stat_loads_q;
    assign bus.stat_stores = stat_stores_q;
    assign bus.stat_wait   = stat_wait_q;

    // Free-running access statistics, frozen once the core has halted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_wait_q   <= '0;
        end else if (!halt_q) begin
            if (rd_hit) begin
                stat_loads_q <= stat_loads_q + 32'd1;
            end
            if (wr_hit) begin
                stat_stores_q <= stat_stores_q + 32'd1;
            end
            if (wait_cyc) begin
                stat_wait_q <= stat_wait_q + 32'd1;
            end
        end
    end
`else
    // Write completions only feed the statistics counters
    logic unused_wr_hit;
    assign unused_wr_hit = wr_hit;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (WAIT_MAX overridden to 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Prints one summary line and finishes on its own.
module tb_mem_access_ctrl;
    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_err;

    mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .WAIT_MAX(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        bus.dREN_i   = 1'b0;
        bus.dWEN_i   = 1'b0;
        bus.addr_i   = '0;
        bus.store_i  = '0;
        bus.halt_i   = 1'b0;
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        RST = 1'b1;

        // ---------------- reset state ----------------
        sample();
        check("rst_ren",      32'(bus.dmemREN), 32'd0);
        check("rst_stall",    32'(bus.mem_stall), 32'd0);
        check("rst_load",     bus.load_o, 32'h0);
        check("rst_ldv",      32'(bus.ld_valid), 32'd0);
        check("rst_halt",     32'(bus.halt_o), 32'd0);
        check("rst_misalign", 32'(bus.err_misalign), 32'd0);
        check("rst_timeout",  32'(bus.err_timeout), 32'd0);
        next_cyc();
        RST = 1'b0;
        next_cyc();

        // ---------------- load, dhit in cycle 3 ----------------
        bus.dREN_i = 1'b1;
        bus.addr_i = 32'h100;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("ld_ren_c%0d", c), 32'(bus.dmemREN), 32'd1);
            check($sformatf("ld_stall_c%0d", c), 32'(bus.mem_stall), 32'd1);
            next_cyc();
        end
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hDEADBEEF;
        sample();
        check("ld_addr_c3",  bus.dmemaddr, 32'h100);
        check("ld_ren_c3",   32'(bus.dmemREN), 32'd1);
        check("ld_stall_c3", 32'(bus.mem_stall), 32'd0);
        next_cyc();
        bus.dhit     = 1'b0;
        bus.dmemload = 32'h0;
        sample();
        check("ld_valid_c4", 32'(bus.ld_valid), 32'd1);
        check("ld_data_c4",  bus.load_o, 32'hDEADBEEF);
        check("ld_ren_done", 32'(bus.dmemREN), 32'd0);
        check("ld_stall_done", 32'(bus.mem_stall), 32'd0);
        next_cyc();
        bus.dREN_i = 1'b0;
        sample();
        check("ld_valid_c5", 32'(bus.ld_valid), 32'd0);
        check("ld_data_hold", bus.load_o, 32'hDEADBEEF);
        next_cyc();

        // ---------------- store, same-cycle dhit ----------------
        bus.dWEN_i  = 1'b1;
        bus.addr_i  = 32'h204;
        bus.store_i = 32'h12345678;
        bus.dhit    = 1'b1;
        sample();
        check("st_wen",   32'(bus.dmemWEN), 32'd1);
        check("st_ren",   32'(bus.dmemREN), 32'd0);
        check("st_data",  bus.dmemstore, 32'h12345678);
        check("st_stall", 32'(bus.mem_stall), 32'd0);
        next_cyc();
        bus.dhit = 1'b0;
        sample();
        check("st_wen_done", 32'(bus.dmemWEN), 32'd0);
        check("st_stall_done", 32'(bus.mem_stall), 32'd0);
        check("st_ldv", 32'(bus.ld_valid), 32'd0);
        next_cyc();
        bus.dWEN_i = 1'b0;
        sample();
        check("st_ldv2", 32'(bus.ld_valid), 32'd0);
        check("st_load_kept", bus.load_o, 32'hDEADBEEF);
        next_cyc();

        // ---------------- both read and write requested ----------------
        bus.dREN_i   = 1'b1;
        bus.dWEN_i   = 1'b1;
        bus.addr_i   = 32'h300;
        bus.store_i  = 32'hA5A5A5A5;
        bus.dmemload = 32'h11111111;
        sample();
        check("both_wen",   32'(bus.dmemWEN), 32'd1);
        check("both_ren",   32'(bus.dmemREN), 32'd0);
        check("both_stall", 32'(bus.mem_stall), 32'd1);
        next_cyc();
        bus.dhit = 1'b1;
        sample();
        check("both_stall_hit", 32'(bus.mem_stall), 32'd0);
        next_cyc();
        bus.dhit = 1'b0;
        sample();
        check("both_ldv",  32'(bus.ld_valid), 32'd0);
        check("both_load", bus.load_o, 32'hDEADBEEF);
        next_cyc();
        clear_inputs();
        next_cyc();

        // ---------------- misaligned load ----------------
        bus.dREN_i = 1'b1;
        bus.addr_i = 32'h102;
        sample();
        check("mis_ren",   32'(bus.dmemREN), 32'd0);
        check("mis_stall", 32'(bus.mem_stall), 32'd0);
        check("mis_flag_pre", 32'(bus.err_misalign), 32'd0);
        next_cyc();
        bus.dREN_i = 1'b0;
        sample();
        check("mis_flag", 32'(bus.err_misalign), 32'd1);
        // dhit with no request is ignored
        next_cyc();
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h55555555;
        next_cyc();
        bus.dhit = 1'b0;
        sample();
        check("idle_hit_ldv",  32'(bus.ld_valid), 32'd0);
        check("idle_hit_load", bus.load_o, 32'hDEADBEEF);
        check("mis_flag_held", 32'(bus.err_misalign), 32'd1);
        next_cyc();

        // ---------------- timeout then reset mid-access ----------------
        bus.dREN_i = 1'b1;
        bus.addr_i = 32'h400;
        for (int c = 0; c < 6; c++) begin
            sample();
            check($sformatf("to_flag_c%0d", c), 32'(bus.err_timeout), (c >= 4) ? 32'd1 : 32'd0);
            check($sformatf("to_ren_c%0d", c), 32'(bus.dmemREN), 32'd1);
            next_cyc();
        end
        RST = 1'b1;
        #1;
        check("rst_mid_ren",   32'(bus.dmemREN), 32'd0);
        check("rst_mid_stall", 32'(bus.mem_stall), 32'd0);
        check("rst_mid_to",    32'(bus.err_timeout), 32'd0);
        check("rst_mid_mis",   32'(bus.err_misalign), 32'd0);
        check("rst_mid_load",  bus.load_o, 32'h0);
        next_cyc();
        bus.dREN_i = 1'b0;
        RST = 1'b0;
        next_cyc();
        // back in IDLE: a same-cycle-hit load issues immediately
        bus.dREN_i   = 1'b1;
        bus.addr_i   = 32'h408;
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h0BADF00D;
        sample();
        check("post_rst_ren",   32'(bus.dmemREN), 32'd1);
        check("post_rst_stall", 32'(bus.mem_stall), 32'd0);
        next_cyc();
        bus.dhit = 1'b0;
        sample();
        check("post_rst_ldv",  32'(bus.ld_valid), 32'd1);
        check("post_rst_load", bus.load_o, 32'h0BADF00D);
        next_cyc();
        clear_inputs();
        next_cyc();

        // ---------------- halt deferred behind a pending load ----------------
        bus.dREN_i = 1'b1;
        bus.addr_i = 32'h500;
        bus.halt_i = 1'b1;
        sample();
        check("halt_c0", 32'(bus.halt_o), 32'd0);
        next_cyc();
        sample();
        check("halt_c1_wait", 32'(bus.halt_o), 32'd0);
        next_cyc();
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hCAFEF00D;
        sample();
        check("halt_c2_hit", 32'(bus.halt_o), 32'd0);
        next_cyc();
        bus.dhit = 1'b0;
        sample();
        check("halt_c3_done", 32'(bus.halt_o), 32'd0);
        check("halt_ld_data", bus.load_o, 32'hCAFEF00D);
        next_cyc();
        bus.dREN_i = 1'b0;
        sample();
        check("halt_c4_idle", 32'(bus.halt_o), 32'd0);
        next_cyc();
        bus.halt_i = 1'b0;
        sample();
        check("halt_c5_set", 32'(bus.halt_o), 32'd1);
        next_cyc();
        sample();
        check("halt_sticky", 32'(bus.halt_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
